// File: rtl/lsu_defs_pkg.sv
// ============================================================================
//  Module   : lsu_defs (package)
//  Purpose  : Shared funct3 codes, fault causes and FSM encoding for the LSU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_defs;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    localparam logic [1:0] c_CAUSE_NONE    = 2'd0;
    localparam logic [1:0] c_CAUSE_MISALGN = 2'd1;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == c_F3_LB) || (f3 == c_F3_LH) || (f3 == c_F3_LW) ||
                   (f3 == c_F3_LBU) || (f3 == c_F3_LHU);
        else
            return (f3 == c_F3_SB) || (f3 == c_F3_SH) || (f3 == c_F3_SW);
    endfunction

    // funct3[1:0] encodes the size for every legal load/store code.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
//  Module   : load_align
//  Purpose  : Selects the addressed byte/halfword of a read word and extends it.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_align
    import lsu_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'd0;
        case (off)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = 8'd0;
        endcase
        w_half = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_data = 32'd0;
        case (funct3)
            c_F3_LB:  ext_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  ext_data = {{16{w_half[15]}}, w_half};
            c_F3_LW:  ext_data = rdata;
            c_F3_LBU: ext_data = {24'd0, w_byte};
            c_F3_LHU: ext_data = {16'd0, w_half};
            default:  ext_data = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Single-outstanding load/store engine on a ready-handshaked bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_defs::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        ls_busy,
    output logic        ls_done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    localparam int c_CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

    lsu_state_t         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_is_load;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic               r_ls_done;
    logic               r_fault;
    logic [1:0]         r_cause;
    logic [31:0]        r_load_data;
    logic               r_dmem_req;
    logic               r_dmem_we;
    logic [31:0]        r_dmem_addr;
    logic [31:0]        r_dmem_wdata;
    logic [3:0]         r_dmem_wstrb;

    logic               w_accept;
    logic               w_is_load;
    logic [1:0]         w_cause;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_load_ext;

    // A simultaneous read+write request is treated as a load.
    assign w_is_load = mem_read;
    assign w_accept  = (r_state == ST_IDLE) && ex_valid && (mem_read || mem_write);
    assign ls_busy   = (r_state == ST_REQ) || w_accept;

    always_comb begin
        w_cause = c_CAUSE_NONE;
        if (!funct3_legal(w_is_load, funct3))
            w_cause = c_CAUSE_ILLEGAL;
        else if (access_misaligned(funct3, addr[1:0]))
            w_cause = c_CAUSE_MISALGN;
    end

    always_comb begin
        w_wdata = store_data;
        w_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    load_align u_load_align (
        .rdata    (dmem_rdata),
        .off      (r_off),
        .funct3   (r_funct3),
        .ext_data (w_load_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_is_load    <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_ls_done    <= 1'b0;
            r_fault      <= 1'b0;
            r_cause      <= c_CAUSE_NONE;
            r_load_data  <= 32'd0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
            r_dmem_wstrb <= 4'd0;
        end else begin
            r_ls_done <= 1'b0;
            r_fault   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_load <= w_is_load;
                        r_funct3  <= funct3;
                        r_off     <= addr[1:0];
                        r_cause   <= w_cause;
                        if (w_cause == c_CAUSE_NONE) begin
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= !w_is_load;
                            r_dmem_addr  <= {addr[31:2], 2'b00};
                            r_dmem_wdata <= w_wdata;
                            r_dmem_wstrb <= w_is_load ? 4'd0 : w_wstrb;
                            r_wait_cnt   <= '0;
                            r_state      <= ST_REQ;
                        end else begin
                            r_ls_done   <= 1'b1;
                            r_fault     <= 1'b1;
                            r_load_data <= 32'd0;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_ready) begin
                        r_dmem_req  <= 1'b0;
                        r_load_data <= r_is_load ? w_load_ext : 32'd0;
                        r_ls_done   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_dmem_req  <= 1'b0;
                        r_cause     <= c_CAUSE_TIMEOUT;
                        r_load_data <= 32'd0;
                        r_ls_done   <= 1'b1;
                        r_fault     <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ls_done     = r_ls_done;
    assign fault       = r_fault;
    assign fault_cause = r_cause;
    assign load_data   = r_load_data;
    assign dmem_req    = r_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign dmem_addr   = r_dmem_addr;
    assign dmem_wdata  = r_dmem_wdata;
    assign dmem_wstrb  = r_dmem_wstrb;

endmodule

`default_nettype wire
